// File: rtl/md4_pkg.sv
// md4_pkg: shared constants and FSM state type for the md4 digest matcher.
package md4_pkg;
    localparam int MD4_DIGEST_BYTES = 16;
    localparam int IDX_W = $clog2(MD4_DIGEST_BYTES);
    typedef enum logic [2:0] {IDLE, LOAD, ARMED, COMPARE, HALTED} state_t;
endpackage

// File: rtl/digest_target_regfile.sv
// digest_target_regfile: 16x8 target digest storage, one write port, combinational read.
// Ports: CLK, RESET_N (async, active-low), clear (sync), we/waddr/wdata write port,
//        raddr -> rdata combinational read.
module digest_target_regfile
    import md4_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             clear,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [7:0]       wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [7:0]       rdata
);
    logic [MD4_DIGEST_BYTES-1:0][7:0] mem;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) mem <= '0;
        else if (clear) mem <= '0;
        else if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/md4_digest_matcher.sv
// md4_digest_matcher: compares streamed md4 digests byte-by-byte against a loaded target.
// Ports: CLK, RESET_N (async, active-low), CLEAR_IN (sync clear);
//        TARGET_BYTE_IN/TARGET_WRITE_IN load the target, TARGET_READY_OUT when all 16 loaded;
//        HASH_BYTE_IN/HASH_WRITE_IN/HASH_FULL_OUT digest byte stream with backpressure,
//        CANDIDATE_ID_IN sampled with byte 0;
//        RESULT_VALID_OUT/MATCH_OUT per-digest result, FOUND_OUT/FOUND_ID_OUT first match,
//        DIGEST_COUNT_OUT digests compared since clear.
module md4_digest_matcher
    import md4_pkg::*;
#(
    parameter int ID_WIDTH      = 32,
    parameter bit HALT_ON_MATCH = 1'b1
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                CLEAR_IN,
    input  logic [7:0]          TARGET_BYTE_IN,
    input  logic                TARGET_WRITE_IN,
    output logic                TARGET_READY_OUT,
    input  logic [7:0]          HASH_BYTE_IN,
    input  logic                HASH_WRITE_IN,
    output logic                HASH_FULL_OUT,
    input  logic [ID_WIDTH-1:0] CANDIDATE_ID_IN,
    output logic                RESULT_VALID_OUT,
    output logic                MATCH_OUT,
    output logic                FOUND_OUT,
    output logic [ID_WIDTH-1:0] FOUND_ID_OUT,
    output logic [31:0]         DIGEST_COUNT_OUT
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(MD4_DIGEST_BYTES - 1);

    state_t              state, state_nx;
    logic [IDX_W-1:0]    load_cnt, byte_cnt;
    logic                mismatch;
    logic [ID_WIDTH-1:0] id_reg;
    logic [7:0]          tgt_byte;
    logic                tgt_we, hash_acc, last_acc, neq, digest_match;

    // Both status outputs decode the state register directly, so they are glitch-free
    // and follow an async reset immediately.
    assign TARGET_READY_OUT = state inside {ARMED, COMPARE, HALTED};
    assign HASH_FULL_OUT    = state inside {IDLE, LOAD, HALTED};

    assign tgt_we       = TARGET_WRITE_IN && (state inside {IDLE, LOAD}) && !CLEAR_IN;
    assign hash_acc     = HASH_WRITE_IN && !HASH_FULL_OUT && !CLEAR_IN;
    assign last_acc     = hash_acc && byte_cnt == LAST;
    assign neq          = HASH_BYTE_IN != tgt_byte;
    assign digest_match = !(mismatch || neq);

    digest_target_regfile u_target (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .clear  (CLEAR_IN),
        .we     (tgt_we),
        .waddr  (load_cnt),
        .wdata  (TARGET_BYTE_IN),
        .raddr  (byte_cnt),
        .rdata  (tgt_byte)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = tgt_we ? LOAD : IDLE;
            LOAD:    state_nx = (tgt_we && load_cnt == LAST) ? ARMED : LOAD;
            ARMED:   state_nx = hash_acc ? COMPARE : ARMED;
            COMPARE: state_nx = last_acc ? ((digest_match && HALT_ON_MATCH) ? HALTED : ARMED) : COMPARE;
            default: state_nx = state;
        endcase
        if (CLEAR_IN) state_nx = IDLE;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N || CLEAR_IN) begin
            load_cnt         <= '0;
            byte_cnt         <= '0;
            mismatch         <= 1'b0;
            id_reg           <= '0;
            RESULT_VALID_OUT <= 1'b0;
            MATCH_OUT        <= 1'b0;
            FOUND_OUT        <= 1'b0;
            FOUND_ID_OUT     <= '0;
            DIGEST_COUNT_OUT <= '0;
        end else begin
            RESULT_VALID_OUT <= last_acc;
            if (tgt_we) load_cnt <= load_cnt + 1'b1;
            if (hash_acc) begin
                byte_cnt <= byte_cnt + 1'b1;
                // byte 0 starts a fresh digest, so the previous flag is discarded
                mismatch <= neq || (byte_cnt != '0 && mismatch);
                if (byte_cnt == '0) id_reg <= CANDIDATE_ID_IN;
            end
            if (last_acc) begin
                MATCH_OUT        <= digest_match;
                DIGEST_COUNT_OUT <= DIGEST_COUNT_OUT + 32'd1;
                if (digest_match && !FOUND_OUT) begin
                    FOUND_OUT    <= 1'b1;
                    FOUND_ID_OUT <= id_reg;
                end
            end
        end
    end
endmodule

// File: tb/tb_md4_digest_matcher.sv
// tb_md4_digest_matcher: checks two matcher instances (no halt / halt on match) against a digest-level model.
module tb_md4_digest_matcher;
    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        CLEAR_IN = 1'b0;
    logic [7:0]  TARGET_BYTE_IN = '0;
    logic        TARGET_WRITE_IN = 1'b0;
    logic [7:0]  HASH_BYTE_IN = '0;
    logic        HASH_WRITE_IN = 1'b0;
    logic [31:0] CANDIDATE_ID_IN = '0;
    logic [1:0]  ready, full, valid, match, found;
    logic [31:0] fid [2];
    logic [31:0] cnt [2];
    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        md4_digest_matcher #(.ID_WIDTH(32), .HALT_ON_MATCH(g == 1)) dut (
            .CLK(CLK), .RESET_N(RESET_N), .CLEAR_IN(CLEAR_IN),
            .TARGET_BYTE_IN(TARGET_BYTE_IN), .TARGET_WRITE_IN(TARGET_WRITE_IN),
            .TARGET_READY_OUT(ready[g]),
            .HASH_BYTE_IN(HASH_BYTE_IN), .HASH_WRITE_IN(HASH_WRITE_IN), .HASH_FULL_OUT(full[g]),
            .CANDIDATE_ID_IN(CANDIDATE_ID_IN),
            .RESULT_VALID_OUT(valid[g]), .MATCH_OUT(match[g]), .FOUND_OUT(found[g]),
            .FOUND_ID_OUT(fid[g]), .DIGEST_COUNT_OUT(cnt[g])
        );
    end

    // Digest-level model: index 0 never halts, index 1 halts on a match.
    logic [7:0]  m_tgt [2][16];
    logic [7:0]  m_dig [2][16];
    int          m_tcnt [2];
    int          m_pos [2];
    logic [31:0] m_id [2];
    bit          m_halt [2];
    bit          e_valid [2], e_match [2], e_found [2];
    logic [31:0] e_fid [2], e_cnt [2];

    function automatic bit m_full(int h);
        return m_tcnt[h] < 16 || m_halt[h];
    endfunction

    function automatic void m_reset(int h);
        m_tcnt[h] = 0; m_pos[h] = 0; m_halt[h] = 0; m_id[h] = 0;
        e_valid[h] = 0; e_match[h] = 0; e_found[h] = 0; e_fid[h] = 0; e_cnt[h] = 0;
        for (int i = 0; i < 16; i++) begin m_tgt[h][i] = 0; m_dig[h][i] = 0; end
    endfunction

    function automatic void m_step(int h);
        bit was_full, eq;
        if (CLEAR_IN) begin m_reset(h); return; end
        was_full = m_full(h);
        e_valid[h] = 0;
        if (TARGET_WRITE_IN && m_tcnt[h] < 16) begin
            m_tgt[h][m_tcnt[h]] = TARGET_BYTE_IN;
            m_tcnt[h]++;
        end
        if (HASH_WRITE_IN && !was_full) begin
            if (m_pos[h] == 0) m_id[h] = CANDIDATE_ID_IN;
            m_dig[h][m_pos[h]] = HASH_BYTE_IN;
            m_pos[h]++;
            if (m_pos[h] == 16) begin
                eq = 1;
                for (int i = 0; i < 16; i++) if (m_dig[h][i] != m_tgt[h][i]) eq = 0;
                m_pos[h] = 0; e_valid[h] = 1; e_match[h] = eq; e_cnt[h]++;
                if (eq && !e_found[h]) begin e_found[h] = 1; e_fid[h] = m_id[h]; end
                if (eq && h == 1) m_halt[h] = 1;
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        for (int h = 0; h < 2; h++) begin
            chk($sformatf("ready%0d", h), ready[h], m_tcnt[h] == 16);
            chk($sformatf("full%0d", h), full[h], m_full(h));
            chk($sformatf("valid%0d", h), valid[h], e_valid[h]);
            chk($sformatf("match%0d", h), match[h], e_match[h]);
            chk($sformatf("found%0d", h), found[h], e_found[h]);
            chk($sformatf("found_id%0d", h), fid[h], e_fid[h]);
            chk($sformatf("count%0d", h), cnt[h], e_cnt[h]);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        for (int h = 0; h < 2; h++) if (!RESET_N) m_reset(h); else m_step(h);
        #1;
        check_outputs();
    endtask

    task automatic do_clear();
        CLEAR_IN = 1; tick(); CLEAR_IN = 0;
    endtask

    task automatic load_target(input logic [127:0] t);
        for (int k = 0; k < 16; k++) begin
            TARGET_WRITE_IN = 1; TARGET_BYTE_IN = t[127-8*k -: 8]; tick();
        end
        TARGET_WRITE_IN = 0; HASH_WRITE_IN = 0;
    endtask

    task automatic stream(input logic [127:0] d, input logic [31:0] id, input int n);
        for (int k = 0; k < n; k++) begin
            HASH_WRITE_IN = 1; HASH_BYTE_IN = d[127-8*k -: 8]; CANDIDATE_ID_IN = id; tick();
        end
        HASH_WRITE_IN = 0;
    endtask

    typedef struct {
        logic [127:0] tgt;
        logic [127:0] dig;
        logic [31:0]  id;
        logic         match;
    } vec_t;

    localparam logic [127:0] EMPTY = 128'h31d6cfe0d16ae931b73c59d7e0c089c0;
    localparam logic [127:0] ABC   = 128'ha448017aaf21d8525fc10ae87aa6729d;

    initial begin
        vec_t vt [4];
        int pulses [$];
        bit pmatch [$];
        logic [127:0] d, rt;
        vt[0] = '{EMPTY, EMPTY, 32'd5, 1'b1};
        vt[1] = '{ABC, 128'ha448017aaf21d8525fc10ae87aa6729c, 32'd7, 1'b0};
        vt[2] = '{ABC, ABC, 32'd9, 1'b1};
        vt[3] = '{ABC, 128'h0048017aaf21d8525fc10ae87aa6729d, 32'd11, 1'b0};

        for (int h = 0; h < 2; h++) m_reset(h);
        #2;
        chk("reset_full", full[0], 1);
        chk("reset_ready", ready[0], 0);
        chk("reset_count", cnt[1], 0);
        tick();
        @(negedge CLK) RESET_N = 1;

        // table-driven single digests
        for (int i = 0; i < 4; i++) begin
            do_clear();
            load_target(vt[i].tgt);
            chk("tv_ready", ready[1], 1);
            chk("tv_full_armed", full[1], 0);
            stream(vt[i].dig, vt[i].id, 16);
            chk("tv_valid", valid[0], 1);
            chk("tv_match", match[1], vt[i].match);
            chk("tv_found", found[1], vt[i].match);
            chk("tv_found_id", fid[1], vt[i].match ? vt[i].id : 0);
            chk("tv_count", cnt[1], 1);
            chk("tv_halt_full", full[1], vt[i].match);
            chk("tv_nohalt_full", full[0], 0);
            tick();
            chk("tv_valid_pulse", valid[0], 0);
            chk("tv_match_hold", match[0], vt[i].match);
        end

        // back-to-back digests, IDs 1..3, only ID 2 matches
        do_clear();
        load_target(ABC);
        for (int k = 0; k < 48; k++) begin
            d = (k / 16 == 0) ? (ABC ^ (128'h1 << 40)) : (k / 16 == 1) ? ABC : 128'ha448017aaf21d8525fc10ae87aa6729c;
            HASH_WRITE_IN = 1; HASH_BYTE_IN = d[127-8*(k%16) -: 8]; CANDIDATE_ID_IN = k / 16 + 1;
            tick();
            if (valid[0]) begin pulses.push_back(k); pmatch.push_back(match[0]); end
        end
        HASH_WRITE_IN = 0;
        chk("b2b_pulses", pulses.size(), 3);
        if (pulses.size() == 3) begin
            chk("b2b_gap1", pulses[1] - pulses[0], 16);
            chk("b2b_gap2", pulses[2] - pulses[1], 16);
            chk("b2b_pattern", {pmatch[0], pmatch[1], pmatch[2]}, 3'b010);
        end
        chk("b2b_found_id", fid[0], 2);
        chk("b2b_count", cnt[0], 3);
        chk("b2b_halt_count", cnt[1], 2);

        // backpressure: writes before the target is complete are dropped
        do_clear();
        HASH_WRITE_IN = 1; HASH_BYTE_IN = 8'h55;
        for (int k = 0; k < 5; k++) tick();
        load_target(ABC);
        stream(ABC, 32'd21, 16);
        chk("bp_match", match[0], 1);
        chk("bp_count", cnt[0], 1);
        chk("bp_found_id", fid[0], 21);

        // mid-digest clear, with a simultaneous target write
        do_clear();
        load_target(ABC);
        stream(ABC, 32'd3, 7);
        CLEAR_IN = 1; TARGET_WRITE_IN = 1; HASH_WRITE_IN = 1; TARGET_BYTE_IN = 8'hee;
        tick();
        CLEAR_IN = 0; HASH_WRITE_IN = 0;
        chk("clr_ready", ready[0], 0);
        chk("clr_full", full[0], 1);
        chk("clr_valid", valid[0], 0);
        for (int k = 0; k < 15; k++) tick();
        chk("clr_load_15", ready[0], 0);
        tick();
        chk("clr_load_16", ready[0], 1);
        TARGET_WRITE_IN = 0;
        tick();

        // async reset while in COMPARE
        do_clear();
        load_target(ABC);
        stream(ABC, 32'd4, 16);
        stream(ABC, 32'd6, 5);
        HASH_WRITE_IN = 1;
        #2 RESET_N = 0;
        for (int h = 0; h < 2; h++) m_reset(h);
        #1;
        chk("arst_full", full[0], 1);
        chk("arst_ready", ready[0], 0);
        chk("arst_count", cnt[0], 0);
        chk("arst_found", found[0], 0);
        chk("arst_found_id", fid[1], 0);
        HASH_WRITE_IN = 0;
        @(negedge CLK) RESET_N = 1;

        // randomized traffic against the model
        rt = {$urandom, $urandom, $urandom, $urandom};
        do_clear();
        for (int n = 0; n < 1500; n++) begin
            CLEAR_IN = ($urandom % 200) == 0;
            TARGET_WRITE_IN = $urandom % 2;
            TARGET_BYTE_IN = (m_tcnt[0] < 16) ? rt[127-8*m_tcnt[0] -: 8] : 8'($urandom);
            HASH_WRITE_IN = ($urandom % 4) != 0;
            HASH_BYTE_IN = (($urandom % 24) == 0) ? 8'($urandom) : rt[127-8*m_pos[0] -: 8];
            CANDIDATE_ID_IN = $urandom;
            tick();
            if (CLEAR_IN) rt = {$urandom, $urandom, $urandom, $urandom};
        end
        CLEAR_IN = 0; TARGET_WRITE_IN = 0; HASH_WRITE_IN = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
